// File: rtl/win_stream_pkg.sv
// Shared types and helpers for the byte-window transmit path.
// Holds the FSM state encoding, default bus geometry and the byte
// selector used to pick one byte out of a packed window.
package win_stream_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int DEF_BYTE_WIDTH = 8;
    localparam int DEF_K_BYTES    = 9;

    // Upper bounds for the generic byte selector; callers zero-extend
    // their window into this width and truncate the result.
    localparam int MAX_BYTE_WIDTH = 64;
    localparam int MAX_WIND_WIDTH = 1024;

    // Byte k of a window lives at bits [k*byte_width +: byte_width].
    function automatic logic [MAX_BYTE_WIDTH-1:0] byte_sel(
        input logic [MAX_WIND_WIDTH-1:0] window,
        input int unsigned               index,
        input int unsigned               byte_width
    );
        return MAX_BYTE_WIDTH'(window >> (index * byte_width));
    endfunction

endpackage

// File: rtl/win_byte_cnt.sv
// Loadable down-counter for the byte index of the window being sent.
// Holds when dec is low, stops at zero, and flags the last byte.
module win_byte_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);

    // Index register: clear beats load beats decrement; never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/window_streamer.sv
// Transmit side of the byte-window bus. Accepts one packed window plus
// a receiver address and streams it MSB byte first with a byte strobe,
// so a shift-left receiver ends up holding the window as sent.
// Optional build macro WIN_STREAMER_PERF_EN adds window/stall counters.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | no transfer; o_ready high (once out of reset)
// ST_SEND | strobing bytes; index counts K_BYTES-1 down to 0
module window_streamer
    import win_stream_pkg::*;
#(
    parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
    parameter int K_BYTES    = DEF_K_BYTES,
    parameter int WIND_WIDTH = DEF_BYTE_WIDTH * DEF_K_BYTES,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [WIND_WIDTH-1:0] i_window,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_flush,
    input  logic                  i_bus_ready,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_enb_byt,
    output logic [BYTE_WIDTH-1:0] o_data_byt,
    output logic                  o_busy,
    output logic                  o_done
`ifdef WIN_STREAMER_PERF_EN
    ,
    output logic [15:0]           o_win_cnt,
    output logic [15:0]           o_stall_cnt
`endif
);

    // A single-byte window still needs a one-bit index register.
    localparam int IDX_W = (K_BYTES > 1) ? $clog2(K_BYTES) : 1;

    if (WIND_WIDTH != BYTE_WIDTH * K_BYTES) begin : g_bad_wind_width
        $error("window_streamer: WIND_WIDTH must equal BYTE_WIDTH*K_BYTES");
    end
    if (WIND_WIDTH > MAX_WIND_WIDTH || BYTE_WIDTH > MAX_BYTE_WIDTH) begin : g_too_wide
        $error("window_streamer: window or byte wider than byte_sel supports");
    end

    state_t                state;
    state_t                state_nxt;
    logic                  rdy_en;
    logic [WIND_WIDTH-1:0] win_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BYTE_WIDTH-1:0] data_q;
    logic                  done_q;
    logic [IDX_W-1:0]      idx;
    logic                  idx_last;
    logic                  ready;
    logic                  enb;
    logic                  busy;
    logic                  in_send;
    logic                  consume;
    logic                  last_consume;
    logic                  accept;

    assign in_send      = (state == ST_SEND);
    assign consume      = in_send && i_bus_ready;
    assign last_consume = consume && idx_last;
    assign accept       = i_valid && ready;

    // Keeps o_ready low while reset is applied and until the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: flush wins; the last byte either chains into a new window or idles.
    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state_nxt = ST_SEND;
                ST_SEND: if (last_consume) state_nxt = accept ? ST_SEND : ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM outputs; ready reopens during the last byte so windows can run back to back.
    always_comb begin
        ready = 1'b0;
        enb   = 1'b0;
        busy  = 1'b0;
        case (state)
            ST_IDLE: ready = rdy_en && !i_flush;
            ST_SEND: begin
                enb   = 1'b1;
                busy  = 1'b1;
                ready = rdy_en && !i_flush && idx_last && i_bus_ready;
            end
            default: ;
        endcase
    end

    win_byte_cnt #(
        .WIDTH (IDX_W)
    ) u_byte_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (i_flush),
        .load     (accept),
        .load_val (IDX_W'(K_BYTES - 1)),
        .dec      (consume),
        .cnt      (idx),
        .last     (idx_last)
    );

    // Window, address and outgoing byte; the next byte is fetched as the current one is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else if (i_flush) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            win_q  <= i_window;
            addr_q <= i_addr;
            data_q <= BYTE_WIDTH'(byte_sel(MAX_WIND_WIDTH'(i_window),
                                           K_BYTES - 1, BYTE_WIDTH));
        end else if (last_consume) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (consume) begin
            data_q <= BYTE_WIDTH'(byte_sel(MAX_WIND_WIDTH'(win_q),
                                           32'(idx) - 32'd1, BYTE_WIDTH));
        end
    end

    // One-cycle completion pulse after the last byte is taken; suppressed by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= last_consume && !i_flush;
        end
    end

    assign o_ready    = ready;
    assign o_enb_byt  = enb;
    assign o_busy     = busy;
    assign o_addr     = addr_q;
    assign o_data_byt = data_q;
    assign o_done     = done_q;

`ifdef WIN_STREAMER_PERF_EN
    logic [15:0] win_cnt;
    logic [15:0] stall_cnt;

    // Saturating counters of completed windows and stalled send cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt   <= '0;
            stall_cnt <= '0;
        end else if (i_flush) begin
            win_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (last_consume && (win_cnt != 16'hFFFF)) begin
                win_cnt <= win_cnt + 16'd1;
            end
            if (in_send && !i_bus_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign o_win_cnt   = win_cnt;
    assign o_stall_cnt = stall_cnt;
`endif

endmodule
